pu_riscv_div_radix: RTL and testbench
=====================================

Name: pu_riscv_div_radix

Overview:
Parametrised iterative integer divider for the PU-RISCV execute stage. It implements DIV/DIVU/REM/REMU and the RV64 word forms DIVW/DIVUW/REMW/REMUW. It retires RADIX_BITS quotient bits per cycle and supports pipeline flush plus stall-aware result hand-off. Sits beside the ALU/MUL in execute; drives the execute stall and the writeback result/bubble.

Parameters:
XLEN, 64, datapath width (32 or 64)
ILEN, 64, instruction width
RADIX_BITS, 1, quotient bits per iteration (1, 2 or 4; must divide 32)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
ex_stall  input  1  execute stage held by another unit
flush  input  1  pipeline kill; aborts any operation in flight
div_stall  output  1  divider busy, holds pipeline
id_bubble  input  1  id_instr invalid
id_instr  input  ILEN  instruction (func7 [31:25], func3 [14:12], opcode [6:2])
opA  input  XLEN  dividend
opB  input  XLEN  divisor
st_xlen  input  2  current XLEN mode; RV32I forces word forms illegal
div_bubble  output  1  0 = div_r valid this cycle
div_r  output  XLEN  result

Behaviour:
- Reset (async, rstn=0): state=IDLE; div_bubble=1, div_stall=0, div_r=0; cnt, remainder, quotient, divisor and sign flags=0.
- div_bubble defaults to 1 every cycle; it drops for exactly one cycle per result.
- IDLE: accept when !ex_stall && !id_bubble && !flush and the decode matches. Unmatched instructions are ignored.
- Single-cycle special cases, result registered next cycle, no stall:
  - divide by zero: DIV/DIVU give all-ones; REM/REMU give opA; W forms give sext32 of the same.
  - signed overflow (min_int / -1): DIV gives min_int, REM gives 0; W forms use 32-bit min_int, sign-extended.
- Normal accept:
  - latch |opA| and |opB| (raw values if unsigned); neg_q = sA^sB, neg_r = sA.
  - W forms: 32-bit operands, dividend left-aligned to XLEN.
  - set cnt = W/RADIX_BITS - 1 (W = 32 or XLEN).
  - assert div_stall next cycle; enter DIV.
- DIV: each cycle performs RADIX_BITS chained restoring steps (shift, subtract, restore-or-keep, shift in quotient bit); cnt decrements. When cnt=0, enter RES after that cycle's step.
- RES:
  - if ex_stall=1, hold (div_stall stays 1, no result).
  - otherwise drive div_r, pulse div_bubble=0, drop div_stall, return to IDLE.
  - result formation: quotient or remainder; conditionally negated (twos) for signed forms; W forms sext32.
- Latency: W/RADIX_BITS + 2 cycles from accept to result (e.g. 66 for XLEN 64, radix 1; 34 for radix 2; 18 for DIVW radix 2).
- flush: in any state, forces IDLE and div_stall=0 next cycle; no result is produced.
  - flush coincident with RES: flush wins, div_bubble stays 1.
  - flush in IDLE blocks acceptance that cycle.
- The instruction is captured at accept, not on every unstalled cycle.
- XLEN=32: W forms never decode.

Optional Feature:
PU_RISCV_DIV_EARLY_EXIT_EN
- Defined:
  - on normal accept, count leading zeros of the aligned dividend and pre-shift it by the largest multiple of RADIX_BITS not exceeding that count.
  - reduce cnt accordingly.
  - dividend 0 or |dividend| < |divisor| goes straight to RES (quotient 0, remainder = dividend).
  - latency becomes data-dependent, minimum 2 cycles.
- Undefined: fixed latency as above; results identical in both builds.

Decomposition:
- pu_riscv_verilog_pkg: existing DIV..REMUW decode patterns and RV32I; add a div_state_t enum (IDLE/DIV/RES) and a DIV_MAX_RADIX constant.
- Sub-module pu_riscv_div_step: combinational single restoring step (inputs p, a, b; outputs next p, next a). Instantiated RADIX_BITS times in a generate chain.

Test Plan:
- DIV 64-bit, opA=-7, opB=2, radix 1: div_stall high for 65 cycles, then div_r=-3 with div_bubble=0 for one cycle; REM on the same operands gives -1.
- DIVU, opB=0, opA=5: one cycle later div_r=0xFFFF_FFFF_FFFF_FFFF, div_stall never asserted; REMU gives 5.
- DIVW, opA=0x8000_0000, opB=0xFFFF_FFFF: div_r=0xFFFF_FFFF_8000_0000, no stall; REMW gives 0.
- DIVUW, opA=0x1_0000_0064, opB=10, RADIX_BITS=2: result 10 after 18 cycles.
- flush asserted mid-DIV (cycle 20): div_stall low next cycle, no div_bubble=0 pulse. A following DIV 100/7 returns 14.
- ex_stall held 3 cycles at RES: result delayed 3 cycles, value unchanged. With PU_RISCV_DIV_EARLY_EXIT_EN, DIVU 3/9 returns 0 within 2 cycles.

Source files
------------

// File: rtl/pu_riscv_verilog_pkg.sv
// Shared PU-RISCV definitions used by the execute-stage divider: the M-extension
// divide decode patterns, the XLEN mode encoding, the divider FSM state type and
// a small decode helper.
package pu_riscv_verilog_pkg;

    // XLEN mode encodings (misa.MXL style)
    localparam logic [1:0] RV32I = 2'b01;
    localparam logic [1:0] RV64I = 2'b10;

    // Decode keys: {func7, func3, opcode[6:2]}
    localparam logic [14:0] DIV   = 15'b0000001_100_01100;
    localparam logic [14:0] DIVU  = 15'b0000001_101_01100;
    localparam logic [14:0] REM   = 15'b0000001_110_01100;
    localparam logic [14:0] REMU  = 15'b0000001_111_01100;
    localparam logic [14:0] DIVW  = 15'b0000001_100_01110;
    localparam logic [14:0] DIVUW = 15'b0000001_101_01110;
    localparam logic [14:0] REMW  = 15'b0000001_110_01110;
    localparam logic [14:0] REMUW = 15'b0000001_111_01110;

    // Largest supported number of quotient bits retired per cycle
    localparam int DIV_MAX_RADIX = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_RES
    } div_state_t;

    typedef struct packed {
        logic valid;
        logic signed_op;
        logic rem_op;
        logic word_op;
    } div_dec_t;

    // Map an instruction key onto the divider operation flags
    function automatic div_dec_t div_decode(input logic [14:0] key);
        div_dec_t d;
        d = '0;
        case (key)
            DIV:     d = '{valid: 1'b1, signed_op: 1'b1, rem_op: 1'b0, word_op: 1'b0};
            DIVU:    d = '{valid: 1'b1, signed_op: 1'b0, rem_op: 1'b0, word_op: 1'b0};
            REM:     d = '{valid: 1'b1, signed_op: 1'b1, rem_op: 1'b1, word_op: 1'b0};
            REMU:    d = '{valid: 1'b1, signed_op: 1'b0, rem_op: 1'b1, word_op: 1'b0};
            DIVW:    d = '{valid: 1'b1, signed_op: 1'b1, rem_op: 1'b0, word_op: 1'b1};
            DIVUW:   d = '{valid: 1'b1, signed_op: 1'b0, rem_op: 1'b0, word_op: 1'b1};
            REMW:    d = '{valid: 1'b1, signed_op: 1'b1, rem_op: 1'b1, word_op: 1'b1};
            REMUW:   d = '{valid: 1'b1, signed_op: 1'b0, rem_op: 1'b1, word_op: 1'b1};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pu_riscv_div_step.sv
// One restoring division step: shift the partial remainder left by one dividend
// bit, trial-subtract the divisor, keep or restore, and shift the quotient bit
// into the low end of the dividend register.
module pu_riscv_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] p,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] p_next,
    output logic [XLEN-1:0] a_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Trial subtract; a borrow out of the top bit means restore
    always_comb begin
        // NOTE: every output gets a value on every path so no latch is inferred.
        shifted = {p, a[XLEN-1]};
        diff    = shifted - {1'b0, b};
        if (diff[XLEN]) begin
            p_next = shifted[XLEN-1:0];
            a_next = {a[XLEN-2:0], 1'b0};
        end else begin
            p_next = diff[XLEN-1:0];
            a_next = {a[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/pu_riscv_div_radix.sv
// Iterative DIV/DIVU/REM/REMU (+ RV64 W forms) for the PU-RISCV execute stage.
// Retires RADIX_BITS quotient bits per cycle through a chain of restoring steps.
// Optional build macro PU_RISCV_DIV_EARLY_EXIT_EN skips leading-zero iterations
// of the dividend; results are identical with or without it.
module pu_riscv_div_radix
    import pu_riscv_verilog_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int ILEN       = 64,
    parameter int RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            div_stall,
    input  logic            id_bubble,
    input  logic [ILEN-1:0] id_instr,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [1:0]      st_xlen,
    output logic            div_bubble,
    output logic [XLEN-1:0] div_r
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    div_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem_p;
    logic [XLEN-1:0] quo_a;
    logic [XLEN-1:0] divisor;
    logic            neg_q;
    logic            neg_r;
    logic            op_rem;
    logic            op_word;

    div_dec_t        dec;
    logic            word_ok;
    logic            accept;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] aligned;
    int              w_bits;
    logic [CNT_W-1:0] cnt_init;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_r;
    logic [XLEN-1:0] res_sel;
    logic [XLEN-1:0] res_val;
    logic [XLEN-1:0] result;
    logic            unused_instr;

    // Only func7/func3/opcode[6:2] take part in decode
    assign unused_instr = ^id_instr;

    assign dec     = div_decode({id_instr[31:25], id_instr[14:12], id_instr[6:2]});
    assign word_ok = !dec.word_op || (XLEN == 64 && st_xlen != RV32I);
    assign accept  = (state == S_IDLE) && !ex_stall && !id_bubble && !flush
                     && dec.valid && word_ok;

    // Operand preparation: width selection, magnitudes and single-cycle special cases
    always_comb begin
        if (dec.word_op) begin
            op_a = dec.signed_op ? sext32(opA[31:0]) : XLEN'(opA[31:0]);
            op_b = dec.signed_op ? sext32(opB[31:0]) : XLEN'(opB[31:0]);
        end else begin
            op_a = opA;
            op_b = opB;
        end
        sign_a   = dec.signed_op & op_a[XLEN-1];
        sign_b   = dec.signed_op & op_b[XLEN-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        aligned  = dec.word_op ? (mag_a << (XLEN - 32)) : mag_a;
        w_bits   = dec.word_op ? 32 : XLEN;
        cnt_init = CNT_W'(w_bits / RADIX_BITS - 1);
        div_zero = (op_b == '0);
        overflow = dec.signed_op && (op_b == '1)
                   && (op_a == (dec.word_op ? sext32(32'h8000_0000) : MIN_INT));
        if (div_zero)
            special_r = dec.rem_op ? (dec.word_op ? sext32(opA[31:0]) : opA) : '1;
        else
            special_r = dec.rem_op ? '0 : op_a;
    end

`ifdef PU_RISCV_DIV_EARLY_EXIT_EN
    int               lz;
    int               lz_cap;
    int               skip;
    logic             early_done;
    logic [CNT_W-1:0] early_cnt;

    // Skip whole iterations covered by leading zeros of the aligned dividend
    always_comb begin
        lz = XLEN;
        for (int i = 0; i < XLEN; i++) begin
            if (aligned[i]) lz = XLEN - 1 - i;
        end
        lz_cap     = (lz > w_bits) ? w_bits : lz;
        skip       = lz_cap - (lz_cap % RADIX_BITS);
        early_done = (skip == w_bits) || (mag_a < mag_b);
        early_cnt  = CNT_W'((w_bits - skip) / RADIX_BITS - 1);
    end
`endif

    // Restoring step chain, RADIX_BITS steps per cycle
    logic [XLEN-1:0] p_chain [RADIX_BITS+1];
    logic [XLEN-1:0] a_chain [RADIX_BITS+1];

    assign p_chain[0] = rem_p;
    assign a_chain[0] = quo_a;

    for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
        pu_riscv_div_step #(.XLEN(XLEN)) u_step (
            .p      (p_chain[g]),
            .a      (a_chain[g]),
            .b      (divisor),
            .p_next (p_chain[g+1]),
            .a_next (a_chain[g+1])
        );
    end

    // Final result: quotient or remainder, sign fix-up, word sign-extension
    always_comb begin
        res_sel = op_rem ? rem_p : quo_a;
        res_val = (op_rem ? neg_r : neg_q) ? -res_sel : res_sel;
        result  = op_word ? sext32(res_val[31:0]) : res_val;
    end

    // Divider FSM with registered stall, bubble and result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            div_bubble <= 1'b1;
            div_stall  <= 1'b0;
            div_r      <= '0;
            cnt        <= '0;
            rem_p      <= '0;
            quo_a      <= '0;
            divisor    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            op_rem     <= 1'b0;
            op_word    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            div_bubble <= 1'b1;
            if (flush) begin
                state     <= S_IDLE;
                div_stall <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            op_rem  <= dec.rem_op;
                            op_word <= dec.word_op;
                            if (div_zero || overflow) begin
                                div_r      <= special_r;
                                div_bubble <= 1'b0;
                            end else begin
                                divisor   <= mag_b;
                                neg_q     <= sign_a ^ sign_b;
                                neg_r     <= sign_a;
                                div_stall <= 1'b1;
`ifdef PU_RISCV_DIV_EARLY_EXIT_EN
                                if (early_done) begin
                                    rem_p <= mag_a;
                                    quo_a <= '0;
                                    cnt   <= '0;
                                    state <= S_RES;
                                end else begin
                                    rem_p <= '0;
                                    quo_a <= aligned << skip;
                                    cnt   <= early_cnt;
                                    state <= S_DIV;
                                end
`else
                                rem_p <= '0;
                                quo_a <= aligned;
                                cnt   <= cnt_init;
                                state <= S_DIV;
`endif
                            end
                        end
                    end
                    S_DIV: begin
                        rem_p <= p_chain[RADIX_BITS];
                        quo_a <= a_chain[RADIX_BITS];
                        cnt   <= cnt - 1'b1;
                        if (cnt == '0) state <= S_RES;
                    end
                    S_RES: begin
                        if (!ex_stall) begin
                            div_r      <= result;
                            div_bubble <= 1'b0;
                            div_stall  <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pu_riscv_div_radix.sv
// Directed bench for pu_riscv_div_radix: one radix-1 and one radix-2 instance
// with shared pipeline controls and separate issue strobes.
module tb_pu_riscv_div_radix;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

`ifdef PU_RISCV_DIV_EARLY_EXIT_EN
    localparam int L_M7 = 5, L_100 = 9, L_1000 = 12, L_DIVUW = 6, L_DIVW20 = 5, L_3_9 = 2;
`else
    localparam int L_M7 = 66, L_100 = 66, L_1000 = 66, L_DIVUW = 18, L_DIVW20 = 18, L_3_9 = 66;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_bubble1 = 1'b1;
    logic        id_bubble2 = 1'b1;
    logic [63:0] id_instr = '0;
    logic [63:0] opa = '0;
    logic [63:0] opb = '0;
    logic [1:0]  st_xlen = 2'b10;
    logic        stall1, bub1, stall2, bub2;
    logic [63:0] r1, r2;

    int assert_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    pu_riscv_div_radix #(.XLEN(64), .ILEN(64), .RADIX_BITS(1)) dut1 (
        .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .flush(flush), .div_stall(stall1),
        .id_bubble(id_bubble1), .id_instr(id_instr), .opA(opa), .opB(opb),
        .st_xlen(st_xlen), .div_bubble(bub1), .div_r(r1)
    );

    pu_riscv_div_radix #(.XLEN(64), .ILEN(64), .RADIX_BITS(2)) dut2 (
        .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .flush(flush), .div_stall(stall2),
        .id_bubble(id_bubble2), .id_instr(id_instr), .opA(opa), .opB(opb),
        .st_xlen(st_xlen), .div_bubble(bub2), .div_r(r2)
    );

    function automatic logic [63:0] mk_instr(input logic [2:0] f3, input logic word);
        return {32'h0, 7'b0000001, 5'd2, 5'd1, f3, 5'd3, (word ? 5'b01110 : 5'b01100), 2'b11};
    endfunction

    function automatic logic cur_bub(input int which);
        return (which == 1) ? bub1 : bub2;
    endfunction

    function automatic logic cur_stall(input int which);
        return (which == 1) ? stall1 : stall2;
    endfunction

    function automatic logic [63:0] cur_r(input int which);
        return (which == 1) ? r1 : r2;
    endfunction

    // Present one instruction; call right after a falling edge
    task automatic drive(input int which, input logic [63:0] instr, input logic [63:0] a, input logic [63:0] b);
        id_instr = instr;
        opa = a;
        opb = b;
        if (which == 1) id_bubble1 = 1'b0;
        else            id_bubble2 = 1'b0;
    endtask

    // Issue one op, wait for its result, check value, latency, stall length and pulse width
    task automatic run_op(input string name, input int which, input logic [2:0] f3, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_r,
                          input int exp_lat, input int hold_at);
        int n, stalls, lat;
        logic [63:0] got;
        logic stall_at_res;
        bit done;
        n = 0; stalls = 0; lat = 0; done = 0; got = '0; stall_at_res = 1'b0;
        @(negedge clk);
        drive(which, mk_instr(f3, word), a, b);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin id_bubble1 = 1'b1; id_bubble2 = 1'b1; end
            if (cur_bub(which) == 1'b0) begin
                done = 1; lat = n; got = cur_r(which); stall_at_res = cur_stall(which);
            end else if (cur_stall(which)) begin
                stalls++;
            end
            if (hold_at > 0) begin
                if (n == hold_at)     ex_stall = 1'b1;
                if (n == hold_at + 3) ex_stall = 1'b0;
            end
        end
        ex_stall = 1'b0;
        assert_cnt++;
        if (!done || got !== exp_r) begin
            fail_cnt++;
            $display("FAIL %s value: got %h (done=%0d) expected %h", name, got, done, exp_r);
        end
        assert_cnt++;
        if (lat != exp_lat) begin
            fail_cnt++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        assert_cnt++;
        if (stalls != exp_lat - 1 || stall_at_res !== 1'b0) begin
            fail_cnt++;
            $display("FAIL %s stall: got %0d cycles (at result %b) expected %0d cycles (at result 0)",
                     name, stalls, stall_at_res, exp_lat - 1);
        end
        @(negedge clk);
        assert_cnt++;
        if (cur_bub(which) !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s pulse: bubble got %b one cycle after result expected 1", name, cur_bub(which));
        end
    endtask

    // Present an op that must not be accepted and watch that nothing happens
    task automatic no_accept(input string name, input int which, input logic [63:0] instr, input logic do_flush);
        bit seen;
        seen = 0;
        @(negedge clk);
        drive(which, instr, 64'd100, 64'd7);
        flush = do_flush;
        repeat (6) begin
            @(negedge clk);
            id_bubble1 = 1'b1; id_bubble2 = 1'b1; flush = 1'b0;
            if (cur_stall(which) || !cur_bub(which)) seen = 1;
        end
        assert_cnt++;
        if (seen) begin
            fail_cnt++;
            $display("FAIL %s: got activity (stall or result) expected none", name);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        assert_cnt += 3;
        if (bub1 !== 1'b1 || bub2 !== 1'b1) begin
            fail_cnt++; $display("FAIL reset_bubble: got %b/%b expected 1/1", bub1, bub2);
        end
        if (stall1 !== 1'b0 || stall2 !== 1'b0) begin
            fail_cnt++; $display("FAIL reset_stall: got %b/%b expected 0/0", stall1, stall2);
        end
        if (r1 !== 64'h0 || r2 !== 64'h0) begin
            fail_cnt++; $display("FAIL reset_result: got %h/%h expected 0/0", r1, r2);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_div_signed();
        run_op("div_m7_2", 1, F3_DIV, 1'b0, -64'sd7, 64'd2, -64'sd3, L_M7, 0);
        run_op("rem_m7_2", 1, F3_REM, 1'b0, -64'sd7, 64'd2, -64'sd1, L_M7, 0);
    endtask

    task automatic test_div_by_zero();
        run_op("divu_5_0",  1, F3_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op("remu_5_0",  1, F3_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
        run_op("remuw_x_0", 2, F3_REMU, 1'b1, 64'h1_8000_0005, 64'h1_0000_0000,
               64'hFFFF_FFFF_8000_0005, 1, 0);
    endtask

    task automatic test_overflow_word();
        run_op("divw_ovf", 1, F3_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
        run_op("remw_ovf", 1, F3_REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1, 0);
    endtask

    task automatic test_word_radix2();
        run_op("divuw_r2", 2, F3_DIVU, 1'b1, 64'h1_0000_0064, 64'd10, 64'd10, L_DIVUW, 0);
        run_op("divw_r2",  2, F3_DIV,  1'b1, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, L_DIVW20, 0);
        run_op("remw_r2",  2, F3_REM,  1'b1, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, L_DIVW20, 0);
    endtask

    task automatic test_flush();
        int n;
        bit pulse;
        pulse = 0;
        @(negedge clk);
        drive(1, mk_instr(F3_DIV, 1'b0), 64'h7FFF_FFFF_FFFF_FFFF, 64'd3);
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            id_bubble1 = 1'b1;
            if (!bub1) pulse = 1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        assert_cnt++;
        if (stall1 !== 1'b0) begin
            fail_cnt++; $display("FAIL flush_stall: got %b expected 0", stall1);
        end
        repeat (80) begin
            @(negedge clk);
            if (!bub1) pulse = 1;
        end
        assert_cnt++;
        if (pulse) begin
            fail_cnt++; $display("FAIL flush_no_result: got a result pulse expected none");
        end
        run_op("div_after_flush", 1, F3_DIV, 1'b0, 64'd100, 64'd7, 64'd14, L_100, 0);
    endtask

    task automatic test_ex_stall_hold();
        run_op("divu_hold", 1, F3_DIVU, 1'b0, 64'd1000, 64'd7, 64'd142, L_1000 + 3, L_1000 - 1);
        run_op("remu_nohold", 1, F3_REMU, 1'b0, 64'd1000, 64'd7, 64'd6, L_1000, 0);
    endtask

    task automatic test_small_dividend();
        run_op("divu_3_9", 1, F3_DIVU, 1'b0, 64'd3, 64'd9, 64'd0, L_3_9, 0);
        run_op("remu_3_9", 1, F3_REMU, 1'b0, 64'd3, 64'd9, 64'd3, L_3_9, 0);
    endtask

    task automatic test_ignored();
        no_accept("mul_ignored", 1, mk_instr(3'b000, 1'b0), 1'b0);
        st_xlen = 2'b01;
        no_accept("rv32_divw_ignored", 2, mk_instr(F3_DIV, 1'b1), 1'b0);
        st_xlen = 2'b10;
        no_accept("flush_blocks_accept", 1, mk_instr(F3_DIV, 1'b0), 1'b1);
    endtask

    initial begin
        test_reset();
        test_div_signed();
        test_div_by_zero();
        test_overflow_word();
        test_word_radix2();
        test_flush();
        test_ex_stall_hold();
        test_small_dividend();
        test_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
